imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port, synchronous-read, 64-word unified memory between two requesters: the instruction-fetch port (IF) and the load/store data port (DM).
- Enables the multi-cycle and pipelined core variants to run from a single memory image instead of separate instruction and data arrays.
- Grants at most one access per cycle, routes read data back to its owner, and prevents fetch starvation under sustained data traffic.

Parameters:
- N, 32, data word width in bits
- AW, 6, word-address width (64 words)
- MAX_WAIT, 4, consecutive denied IF cycles after which IF takes priority (range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_valid  out  1  if_rdata valid (registered)
- if_rdata  out  N  fetched instruction
- dm_req  in  1  data request; held with its fields until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_be  in  4  byte enables for the store (sb/sh/sw)
- dm_addr  in  AW  data word address
- dm_wdata  in  N  store data
- dm_gnt  out  1  data access accepted this cycle (combinational)
- dm_valid  out  1  load data ready or store acknowledged (registered)
- dm_rdata  out  N  load data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  AW  memory word address
- mem_wdata  out  N  memory write data
- mem_rdata  in  N  memory read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Reset values (rst_n=0 at an edge): if_valid=0, dm_valid=0, owner register=OWN_NONE, wait counter=0.
  - if_gnt, dm_gnt and mem_en are forced to 0 while rst_n=0.
  - Any in-flight response is dropped; no valid pulse follows reset.
- Arbitration is combinational each cycle:
  - Only one of if_req/dm_req high: that requester is granted.
  - Both high: DM wins, unless wait counter == MAX_WAIT, in which case IF wins.
- Granted requester drives mem_* in the same cycle:
  - IF grant: mem_we=0, mem_be=4'b0000.
  - DM load: mem_we=0, mem_be=4'b0000.
  - DM store: mem_we=1, mem_be=dm_be, mem_wdata=dm_wdata.
  - No grant: mem_en=0; other mem_* outputs are 0.
- Owner register latches the grant target (OWN_IF/OWN_DM/OWN_NONE) at every edge.
  - Next cycle: the owner's *_valid=1 for exactly one cycle.
  - *_rdata = mem_rdata while that owner's valid is high, 0 otherwise.
- Latency: grant in cycle T produces valid in cycle T+1.
- Back-to-back: a new grant is allowed in T+1 while T's response is returned. Throughput is one access per cycle.
- Store with dm_be=0: granted with mem_we=1, mem_be=0. Memory contents are unchanged; dm_valid still pulses.
- Wait counter:
  - Increments (saturating at MAX_WAIT) on each cycle with if_req=1 and if_gnt=0.
  - Clears on an IF grant or when if_req=0.
- Addresses are word addresses; there is no wrap or overflow logic. Address 63 is a legal access.
- Requesters must hold req and fields stable until gnt. Dropping req before gnt is legal, and no response is produced for it.
- Simultaneous reset and request: reset wins; no grant is issued in that cycle.

Decomposition:
- Shared package holds:
  - owner_t enum: OWN_NONE, OWN_IF, OWN_DM
  - N and AW defaults
  - BE_NONE=4'b0000 and BE_WORD=4'b1111 constants
- One sub-module, arb_wait_ctr: saturating starvation counter with a synchronous active-low clear. Outputs the count and an at_max flag.

Test Plan:
- Reset, then if_req=1 with if_addr=3 and mem word 3 = 0x00A00093 → if_gnt=1 same cycle; next cycle if_valid=1, if_rdata=0x00A00093, dm_valid=0.
- Store then load: dm_req=1, dm_we=1, dm_be=4'b1111, dm_addr=10, wdata=0xDEADBEEF; then a load from address 10 → dm_valid pulses after each; load returns dm_rdata=0xDEADBEEF.
- Byte store: dm_be=4'b0001, wdata=0x000000AB to a word holding 0x11223344 → a later load returns 0x112233AB.
- Contention with MAX_WAIT=4: if_req and dm_req held high for 8 cycles → dm_gnt in cycles 0–3, if_gnt in cycle 4, then the counter clears and dm_gnt is given again in cycle 5.
- Reset mid-operation: grant a load in cycle T and assert rst_n=0 at T+1 → dm_valid stays 0 and the owner register returns to OWN_NONE.
- Edge address and empty store: if_addr=63 reads correctly; a dm_be=0 store leaves memory unchanged and dm_valid=1 for one cycle.

Source files
------------

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
//   owner_t : which requester owns the response returned in the next cycle
//   N_DEF / AW_DEF : default word width and word-address width
//   BE_NONE / BE_WORD : byte-enable patterns for "no bytes" and "whole word"
package imem_dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam int N_DEF  = 32;
  localparam int AW_DEF = 6;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/imem_dmem_arbiter_wait_ctr.sv
// arb_wait_ctr: saturating starvation counter for the fetch port.
// Ports:
//   clk    : rising-edge clock
//   clr_n  : synchronous active-low clear (wins over inc)
//   inc    : count up by one this cycle, holding at MAX_WAIT
//   count  : current count
//   at_max : count has reached MAX_WAIT
module arb_wait_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       inc,
  output logic [3:0] count,
  output logic       at_max
);

  localparam logic [3:0] MAX_C = 4'(MAX_WAIT);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign count  = cnt_q;
  assign at_max = (cnt_q == MAX_C);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port, synchronous-read memory between
// the instruction-fetch port (if_*) and the load/store port (dm_*).
//
// Handshake: a requester raises *_req with its fields and holds them stable
// until *_gnt is seen high in the same cycle; the grant is combinational and
// the access happens at that clock edge. Exactly one cycle later *_valid is
// high for one cycle and *_rdata carries the read data (loads/fetches) or the
// store is acknowledged. *_req may be dropped before a grant; nothing is
// returned for it. A new grant may be issued while the previous response is
// being returned, giving one access per cycle.
//
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   if_req/if_addr -> if_gnt         : fetch request / accept
//   if_valid/if_rdata                : fetch response
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata -> dm_gnt : data request / accept
//   dm_valid/dm_rdata                : load data or store acknowledge
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata, mem_rdata : memory side
//   dbg_owner, dbg_wait              : owner register and starvation count
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int AW       = AW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [N-1:0]  if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [N-1:0]  dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [N-1:0]  dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  output owner_t        dbg_owner,
  output logic [3:0]    dbg_wait
);

  owner_t owner_q, owner_d;
  logic   wait_at_max;
  logic   wait_inc;

  // Grant selection and memory drive. DM has priority on contention unless
  // the fetch port has been denied MAX_WAIT cycles in a row.
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    owner_d   = OWN_NONE;
    mem_we    = 1'b0;
    mem_be    = BE_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (if_req && (!dm_req || wait_at_max)) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end
    end
    if (if_gnt) begin
      owner_d  = OWN_IF;
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      owner_d  = OWN_DM;
      mem_addr = dm_addr;
      if (dm_we) begin
        mem_we    = 1'b1;
        mem_be    = dm_be;
        mem_wdata = dm_wdata;
      end
    end
  end

  assign mem_en = if_gnt | dm_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Valid is qualified with rst_n so a response granted just before reset
  // asserts is dropped rather than pulsing in the reset cycle.
  assign if_valid = rst_n && (owner_q == OWN_IF);
  assign dm_valid = rst_n && (owner_q == OWN_DM);
  assign if_rdata = if_valid ? mem_rdata : '0;
  assign dm_rdata = dm_valid ? mem_rdata : '0;

  // Counts while fetch is requesting but denied; any other cycle clears it.
  assign wait_inc = if_req & ~if_gnt;

  arb_wait_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_ctr (
    .clk   (clk),
    .clr_n (rst_n & wait_inc),
    .inc   (wait_inc),
    .count (dbg_wait),
    .at_max(wait_at_max)
  );

  assign dbg_owner = owner_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed scenarios followed by random traffic,
// a reference model of arbitration and memory contents, and a monitor that
// checks each returned response against the expected queue.
module tb_imem_dmem_arbiter;
  import imem_dmem_arbiter_pkg::*;

  localparam int N        = 32;
  localparam int AW       = 6;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_valid;
  logic [N-1:0]  if_rdata;
  logic          dm_req, dm_we;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [N-1:0]  dm_wdata;
  logic          dm_gnt, dm_valid;
  logic [N-1:0]  dm_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata;
  owner_t        dbg_owner;
  logic [3:0]    dbg_wait;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  imem_dmem_arbiter #(.N(N), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_valid(dm_valid),
    .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_owner(dbg_owner), .dbg_wait(dbg_wait)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory environment ----------------
  logic [N-1:0] sram [64];
  logic [N-1:0] rd_q = '0;
  assign mem_rdata = rd_q;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        rd_q <= sram[mem_addr];
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [N-1:0] ref_mem [64];
  int           model_wait = 0;
  logic [N-1:0] if_exp_q[$];
  int           if_cyc_q[$];
  logic [N-1:0] dm_exp_q[$];
  int           dm_cyc_q[$];
  bit           dm_st_q[$];

  function automatic logic [N-1:0] merge(input logic [N-1:0] old_w,
                                         input logic [N-1:0] new_w,
                                         input logic [3:0] be);
    logic [N-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Predictor: decides who must win from the request pattern and the number
  // of consecutive denied fetch cycles, checks the grant and memory drive,
  // and queues the response expected in the following cycle.
  always @(negedge clk) begin
    bit exp_if, exp_dm;
    if (!rst_n) begin
      total++;
      if (if_gnt !== 1'b0 || dm_gnt !== 1'b0 || mem_en !== 1'b0) begin
        bad++;
        $display("FAIL reset_gnt: if_gnt=%b dm_gnt=%b mem_en=%b required 0 0 0",
                 if_gnt, dm_gnt, mem_en);
      end
      if_exp_q.delete(); if_cyc_q.delete();
      dm_exp_q.delete(); dm_cyc_q.delete(); dm_st_q.delete();
      model_wait = 0;
    end else begin
      exp_if = if_req && (!dm_req || model_wait == MAX_WAIT);
      exp_dm = dm_req && !exp_if;
      total++;
      if (if_gnt !== exp_if || dm_gnt !== exp_dm) begin
        bad++;
        $display("FAIL grant @%0d: if_gnt=%b dm_gnt=%b required %b %b",
                 cyc, if_gnt, dm_gnt, exp_if, exp_dm);
      end
      total++;
      if (exp_if) begin
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b0 ||
            mem_addr !== if_addr) begin
          bad++;
          $display("FAIL mem_if @%0d: en=%b we=%b be=%h addr=%0d required 1 0 0 %0d",
                   cyc, mem_en, mem_we, mem_be, mem_addr, if_addr);
        end
        if_exp_q.push_back(ref_mem[if_addr]);
        if_cyc_q.push_back(cyc);
      end else if (exp_dm) begin
        if (mem_en !== 1'b1 || mem_we !== dm_we || mem_addr !== dm_addr ||
            mem_be !== (dm_we ? dm_be : 4'b0) ||
            mem_wdata !== (dm_we ? dm_wdata : '0)) begin
          bad++;
          $display("FAIL mem_dm @%0d: en=%b we=%b be=%h addr=%0d wd=%h required we=%b be=%h addr=%0d wd=%h",
                   cyc, mem_en, mem_we, mem_be, mem_addr, mem_wdata,
                   dm_we, dm_we ? dm_be : 4'b0, dm_addr, dm_we ? dm_wdata : '0);
        end
        dm_exp_q.push_back(dm_we ? '0 : ref_mem[dm_addr]);
        dm_cyc_q.push_back(cyc);
        dm_st_q.push_back(dm_we);
        if (dm_we) ref_mem[dm_addr] = merge(ref_mem[dm_addr], dm_wdata, dm_be);
      end else begin
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'b0 ||
            mem_addr !== '0 || mem_wdata !== '0) begin
          bad++;
          $display("FAIL mem_idle @%0d: en=%b we=%b be=%h addr=%0d wd=%h required all 0",
                   cyc, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
        end
      end
      if (if_req && !exp_if) model_wait = (model_wait < MAX_WAIT) ? model_wait + 1 : MAX_WAIT;
      else model_wait = 0;
    end
  end

  // Monitor: pops an expected response whenever a port presents valid and
  // flags unexpected or missing responses.
  always @(negedge clk) begin
    logic [N-1:0] e;
    bit st;
    if (!rst_n) begin
      total++;
      if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_valid: if_valid=%b dm_valid=%b required 0 0", if_valid, dm_valid);
      end
    end else begin
      // fetch port
      total++;
      if (if_valid === 1'b1) begin
        if (if_cyc_q.size() > 0 && if_cyc_q[0] == cyc - 1) begin
          e = if_exp_q.pop_front(); void'(if_cyc_q.pop_front());
          if (if_rdata !== e) begin
            bad++;
            $display("FAIL if_rdata @%0d: got %h required %h", cyc, if_rdata, e);
          end
        end else begin
          bad++;
          $display("FAIL if_unexpected_valid @%0d: if_valid=1 required 0", cyc);
        end
      end else begin
        if (if_rdata !== '0) begin
          bad++;
          $display("FAIL if_rdata_idle @%0d: got %h required 0", cyc, if_rdata);
        end
        if (if_cyc_q.size() > 0 && if_cyc_q[0] < cyc) begin
          bad++;
          $display("FAIL if_missing_valid @%0d: if_valid=%b required 1", cyc, if_valid);
          void'(if_exp_q.pop_front()); void'(if_cyc_q.pop_front());
        end
      end
      // data port
      total++;
      if (dm_valid === 1'b1) begin
        if (dm_cyc_q.size() > 0 && dm_cyc_q[0] == cyc - 1) begin
          e = dm_exp_q.pop_front(); void'(dm_cyc_q.pop_front());
          st = dm_st_q.pop_front();
          if (!st && dm_rdata !== e) begin
            bad++;
            $display("FAIL dm_rdata @%0d: got %h required %h", cyc, dm_rdata, e);
          end
        end else begin
          bad++;
          $display("FAIL dm_unexpected_valid @%0d: dm_valid=1 required 0", cyc);
        end
      end else begin
        if (dm_rdata !== '0) begin
          bad++;
          $display("FAIL dm_rdata_idle @%0d: got %h required 0", cyc, dm_rdata);
        end
        if (dm_cyc_q.size() > 0 && dm_cyc_q[0] < cyc) begin
          bad++;
          $display("FAIL dm_missing_valid @%0d: dm_valid=%b required 1", cyc, dm_valid);
          void'(dm_exp_q.pop_front()); void'(dm_cyc_q.pop_front());
          void'(dm_st_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(input bit is_if, input string name);
    bit got = 0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      got = is_if ? if_gnt : dm_gnt;
      if (!got) begin @(posedge clk); #1; end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_timeout: gnt=0 required 1 within 16 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_if(input logic [AW-1:0] a);
    if_req = 1'b1; if_addr = a;
    wait_gnt(1'b1, "if");
    if_req = 1'b0;
  endtask

  task automatic do_dm(input logic we, input logic [3:0] be,
                       input logic [AW-1:0] a, input logic [N-1:0] wd);
    dm_req = 1'b1; dm_we = we; dm_be = be; dm_addr = a; dm_wdata = wd;
    wait_gnt(1'b0, "dm");
    dm_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] dm_pat;
    bit hit_if, hit_dm;
    logic [N-1:0] v;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      sram[i] = v; ref_mem[i] = v;
    end
    sram[3]  = 32'h00A00093; ref_mem[3]  = 32'h00A00093;
    sram[20] = 32'h11223344; ref_mem[20] = 32'h11223344;

    idle(3);
    @(negedge clk);
    total++;
    if (dbg_owner !== OWN_NONE || dbg_wait !== 4'd0) begin
      bad++;
      $display("FAIL reset_state: owner=%0d wait=%0d required 0 0", dbg_owner, dbg_wait);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // fetch, store/load, byte store, edge address, empty store
    do_if(6'd3);
    idle(1);
    do_dm(1'b1, BE_WORD, 6'd10, 32'hDEADBEEF);
    do_dm(1'b0, BE_NONE, 6'd10, '0);
    do_dm(1'b1, 4'b0001, 6'd20, 32'h000000AB);
    do_dm(1'b0, BE_NONE, 6'd20, '0);
    do_if(6'd63);
    do_dm(1'b1, BE_NONE, 6'd40, 32'hFFFFFFFF);
    do_dm(1'b0, BE_NONE, 6'd40, '0);
    idle(2);

    // contention: both held for 8 cycles
    if_req = 1'b1; if_addr = 6'd5;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = '0; dm_addr = 6'd6;
    dm_pat = 8'b1110_1111;  // bit i: DM expected to win in cycle i
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (dm_gnt !== dm_pat[i] || if_gnt !== ~dm_pat[i]) begin
        bad++;
        $display("FAIL contention[%0d]: dm_gnt=%b if_gnt=%b required %b %b",
                 i, dm_gnt, if_gnt, dm_pat[i], ~dm_pat[i]);
      end
      @(posedge clk); #1;
    end
    if_req = 1'b0; dm_req = 1'b0;
    idle(2);

    // reset right after a granted load
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 6'd7;
    @(negedge clk);
    total++;
    if (dm_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_gnt: dm_gnt=%b required 1", dm_gnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    total++;
    if (dm_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_valid: dm_valid=%b required 0", dm_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (dbg_owner !== OWN_NONE || dm_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_owner: owner=%0d dm_valid=%b required 0 0", dbg_owner, dm_valid);
    end
    @(posedge clk); #1;

    // random traffic, including requests withdrawn before grant
    hit_if = 1'b1; hit_dm = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (hit_if || !if_req || $urandom_range(0, 15) == 0) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = AW'($urandom_range(0, 63));
      end
      if (hit_dm || !dm_req || $urandom_range(0, 15) == 0) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = $urandom_range(0, 1);
        dm_be    = 4'($urandom_range(0, 15));
        dm_addr  = AW'($urandom_range(0, 63));
        dm_wdata = $urandom;
      end
      @(negedge clk);
      hit_if = if_gnt; hit_dm = dm_gnt;
      @(posedge clk); #1;
    end
    if_req = 1'b0; dm_req = 1'b0;
    idle(4);

    total++;
    if (if_exp_q.size() != 0 || dm_exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: if_pending=%0d dm_pending=%0d required 0 0",
               if_exp_q.size(), dm_exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
